// File: rtl/game_flow_controller.sv
// Frogger game-flow sequencer: start/countdown/run/hit-freeze/game-over with lives and level.
// Optional feature: define BONUS_LIFE_EN to grant a life on every level-up to a multiple of 4.
module game_flow_controller #(
    parameter int unsigned C_MAX_LIVES         = 3,
    parameter int unsigned C_COUNTDOWN_FRAMES  = 180,
    parameter int unsigned C_HIT_FREEZE_FRAMES = 60,
    parameter int unsigned C_GAME_OVER_FRAMES  = 240,
    parameter int unsigned C_MAX_LEVEL         = 15,
    parameter int unsigned C_FRAME_CNT_W       = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Frame_Tick,
    input  logic                   i_Start,
    input  logic                   i_Has_Collided,
    input  logic                   i_Level_Up,
    output logic [2:0]             o_State,
    output logic                   o_Game_Active,
    output logic                   o_Freeze,
    output logic                   o_Respawn,
    output logic [C_MAX_LIVES-1:0] o_Lives,
    output logic [3:0]             o_Level,
    output logic [1:0]             o_Countdown,
    output logic                   o_Game_Over
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StCountdown = 3'd1,
        StRunning   = 3'd2,
        StHitFreeze = 3'd3,
        StGameOver  = 3'd4
    } state_e;

    localparam logic [C_FRAME_CNT_W-1:0] CNT_ONE = C_FRAME_CNT_W'(1);
    localparam logic [C_FRAME_CNT_W-1:0] CD_LAST = C_FRAME_CNT_W'(C_COUNTDOWN_FRAMES - 1);
    localparam logic [C_FRAME_CNT_W-1:0] HF_LAST = C_FRAME_CNT_W'(C_HIT_FREEZE_FRAMES - 1);
    localparam logic [C_FRAME_CNT_W-1:0] GO_LAST = C_FRAME_CNT_W'(C_GAME_OVER_FRAMES - 1);
    // First counter values where counter*3/N reaches 1 and 2 (ceil of N/3 and 2N/3).
    localparam logic [C_FRAME_CNT_W-1:0] CD_T1 = C_FRAME_CNT_W'((C_COUNTDOWN_FRAMES + 2) / 3);
    localparam logic [C_FRAME_CNT_W-1:0] CD_T2 =
        C_FRAME_CNT_W'((2 * C_COUNTDOWN_FRAMES + 2) / 3);
    localparam logic [3:0] MAX_LEVEL = 4'(C_MAX_LEVEL);

    state_e                   state_q;
    logic [C_FRAME_CNT_W-1:0] frame_cnt_q;
    logic                     start_q;
    logic                     coll_q;

    logic                     start_evt;
    logic                     coll_evt;
    logic [C_FRAME_CNT_W-1:0] cnt_inc;
    logic [C_MAX_LIVES-1:0]   lives_shr;
    logic [3:0]               level_next;

    function automatic logic [1:0] countdown_of(input logic [C_FRAME_CNT_W-1:0] cnt);
        if (cnt >= CD_T2) begin
            return 2'd1;
        end else if (cnt >= CD_T1) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

    assign start_evt  = i_Start & ~start_q;
    assign coll_evt   = i_Has_Collided & ~coll_q;
    assign cnt_inc    = frame_cnt_q + CNT_ONE;
    assign lives_shr  = o_Lives >> 1;
    assign level_next = (o_Level == MAX_LEVEL) ? o_Level : o_Level + 4'd1;
    assign o_State    = state_q;

`ifdef BONUS_LIFE_EN
    localparam logic [C_MAX_LIVES-1:0] LIVES_LSB = C_MAX_LIVES'(1);
    logic                   bonus;
    logic [C_MAX_LIVES-1:0] lives_bonus;
    assign bonus       = (level_next != o_Level) && (level_next[1:0] == 2'b00);
    assign lives_bonus = (o_Lives << 1) | LIVES_LSB;
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q       <= StIdle;
            frame_cnt_q   <= '0;
            start_q       <= 1'b0;
            coll_q        <= 1'b0;
            o_Game_Active <= 1'b0;
            o_Freeze      <= 1'b0;
            o_Respawn     <= 1'b0;
            o_Lives       <= '1;
            o_Level       <= 4'd0;
            o_Countdown   <= 2'd0;
            o_Game_Over   <= 1'b0;
        end else begin
            start_q   <= i_Start;
            coll_q    <= i_Has_Collided;
            o_Respawn <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_evt) begin
                        state_q     <= StCountdown;
                        frame_cnt_q <= '0;
                        o_Lives     <= '1;
                        o_Level     <= 4'd0;
                        o_Freeze    <= 1'b1;
                        o_Countdown <= 2'd3;
                        o_Respawn   <= 1'b1;
                    end
                end
                StCountdown: begin
                    if (i_Frame_Tick) begin
                        if (frame_cnt_q == CD_LAST) begin
                            state_q       <= StRunning;
                            frame_cnt_q   <= '0;
                            o_Countdown   <= 2'd0;
                            o_Freeze      <= 1'b0;
                            o_Game_Active <= 1'b1;
                        end else begin
                            frame_cnt_q <= cnt_inc;
                            o_Countdown <= countdown_of(cnt_inc);
                        end
                    end
                end
                StRunning: begin
                    // A collision pre-empts any level-up (and bonus) in the same cycle.
                    if (coll_evt) begin
                        o_Lives       <= lives_shr;
                        frame_cnt_q   <= '0;
                        o_Game_Active <= 1'b0;
                        if (lives_shr == '0) begin
                            state_q     <= StGameOver;
                            o_Game_Over <= 1'b1;
                        end else begin
                            state_q  <= StHitFreeze;
                            o_Freeze <= 1'b1;
                        end
                    end else if (i_Level_Up) begin
                        o_Level   <= level_next;
                        o_Respawn <= 1'b1;
`ifdef BONUS_LIFE_EN
                        if (bonus) begin
                            o_Lives <= lives_bonus;
                        end
`endif
                    end
                end
                StHitFreeze: begin
                    if (i_Frame_Tick) begin
                        if (frame_cnt_q == HF_LAST) begin
                            state_q       <= StRunning;
                            frame_cnt_q   <= '0;
                            o_Freeze      <= 1'b0;
                            o_Game_Active <= 1'b1;
                            o_Respawn     <= 1'b1;
                        end else begin
                            frame_cnt_q <= cnt_inc;
                        end
                    end
                end
                StGameOver: begin
                    if (i_Frame_Tick) begin
                        if (frame_cnt_q == GO_LAST) begin
                            state_q     <= StIdle;
                            frame_cnt_q <= '0;
                            o_Game_Over <= 1'b0;
                        end else begin
                            frame_cnt_q <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    frame_cnt_q   <= '0;
                    o_Game_Active <= 1'b0;
                    o_Freeze      <= 1'b0;
                    o_Countdown   <= 2'd0;
                    o_Game_Over   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Central game-flow sequencer for Frogger. Takes debounced switch start requests, the collision flag from the collision checker, the level-up pulse from character control, and a per-frame tick from the VGA timing. Produces lives, level, the game-active/freeze enables for the character and obstacle stages, the respawn pulse, and a countdown value for the seven-segment and LED stage.

Parameters:
C_MAX_LIVES, 3, starting lives; thermometer width of o_Lives (1..7)
C_COUNTDOWN_FRAMES, 180, frames spent in COUNTDOWN before RUNNING
C_HIT_FREEZE_FRAMES, 60, frames frozen after a hit
C_GAME_OVER_FRAMES, 240, frames GAME_OVER is held before IDLE
C_MAX_LEVEL, 15, saturation value of o_Level
C_FRAME_CNT_W, 8, frame counter width; must hold the largest *_FRAMES value

Ports:
i_Clk  in  1  system clock (25 MHz pixel clock)
i_Rst_L  in  1  reset; synchronous, active-low
i_Frame_Tick  in  1  one-cycle pulse per frame (end of visible area)
i_Start  in  1  all four debounced switches pressed (level)
i_Has_Collided  in  1  collision flag (level, may stay high several cycles)
i_Level_Up  in  1  one-cycle pulse when the frog reaches the top row
o_State  out  3  IDLE=0, COUNTDOWN=1, RUNNING=2, HIT_FREEZE=3, GAME_OVER=4
o_Game_Active  out  1  high only in RUNNING
o_Freeze  out  1  high in COUNTDOWN and HIT_FREEZE
o_Respawn  out  1  one-cycle pulse; frog returns to base position
o_Lives  out  C_MAX_LIVES  thermometer, LSB-aligned (3'b111 full)
o_Level  out  4  current level, 0-based
o_Countdown  out  2  remaining countdown seconds, 3..1; 0 outside COUNTDOWN
o_Game_Over  out  1  high in GAME_OVER

Behaviour:
- Reset (i_Rst_L=0 at a clock edge, any state): state IDLE, o_Lives all ones, o_Level 0, frame counter 0, all pulses and flags 0, o_Countdown 0, edge registers 0. A reset in any state aborts that state immediately.
- All outputs are registered. Every state change is visible one cycle after the triggering input.
- Edge detect: a collision event is the rising edge of i_Has_Collided. A start event is the rising edge of i_Start. A level held high does not re-trigger.
- IDLE: on a start event, load o_Lives with all ones, set o_Level to 0, clear the frame counter, go to COUNTDOWN, and pulse o_Respawn.
- COUNTDOWN:
  - The frame counter increments on i_Frame_Tick only.
  - o_Countdown = 3 − (counter·3 / C_COUNTDOWN_FRAMES). Implement as thirds compared against constant thresholds; no divider.
  - When the counter reaches C_COUNTDOWN_FRAMES−1 and a tick arrives, go to RUNNING and clear the counter.
  - Collisions and level-ups in this state are ignored.
- RUNNING:
  - Collision event: shift o_Lives right by 1.
    - If o_Lives was 1 before the shift, go to GAME_OVER.
    - Otherwise go to HIT_FREEZE.
  - Level-up pulse: o_Level increments, saturating at C_MAX_LEVEL, and o_Respawn pulses.
  - Collision and level-up in the same cycle: the collision wins and the level-up is dropped.
- HIT_FREEZE: after C_HIT_FREEZE_FRAMES ticks, pulse o_Respawn and return to RUNNING. Inputs other than ticks are ignored.
- GAME_OVER: o_Lives is 0. After C_GAME_OVER_FRAMES ticks, go to IDLE; o_Lives and o_Level hold their values until the next start. A start event during GAME_OVER is ignored.
- A start event while not in IDLE is ignored.
- The frame counter wraps to 0 on every state change and never overflows (parameter constraint).
- An i_Frame_Tick coinciding with a state change does not count toward the new state.

Optional Feature:
BONUS_LIFE_EN
- Defined: every level-up that makes o_Level a nonzero multiple of 4 also shifts a 1 into o_Lives (lives' = (lives<<1)|1), saturating at all ones. The bonus is suppressed if the same cycle carries a collision (collision wins).
- Undefined: lives never increase after start; the bonus logic is absent.

Test Plan:
- Reset mid-RUNNING with o_Level=5, o_Lives=3'b011 -> next cycle o_State=0, o_Lives=3'b111, o_Level=0, o_Respawn=0.
- Countdown with C_COUNTDOWN_FRAMES=6: start edge -> o_Respawn pulse one cycle later, o_Countdown 3,3,2,2,1,1 across ticks, then o_State=2 and o_Game_Active=1 after the 6th tick.
- i_Has_Collided held high 10 cycles in RUNNING -> exactly one decrement, 3'b111 -> 3'b011, o_State=3. After C_HIT_FREEZE_FRAMES=4 ticks -> o_Respawn pulse and o_State=2.
- Three collisions -> o_Lives 3'b011, 3'b001, 3'b000. The third goes directly to o_State=4 with o_Game_Over=1, then to IDLE after C_GAME_OVER_FRAMES ticks. i_Start held throughout does not restart the game; a new start edge does.
- Simultaneous i_Level_Up and collision edge at o_Level=2 -> o_Level stays 2 and o_Lives decrements. 16 level-ups -> o_Level saturates at 15.
- BONUS_LIFE_EN with o_Lives=3'b001: level-up from 3 to 4 -> o_Lives=3'b011. Without the macro -> o_Lives stays 3'b001.
